// File: rtl/atmo_light_est_if.sv
// Pixel-stream and atmospheric-light bundle between the video pipeline and
// atmo_light_est. The master side drives pixels and observes A; the slave
// side (the estimator) consumes pixels and publishes A.
interface atmo_light_est_if;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       in_valid;
  logic       in_sof;
  logic       in_eof;
  logic [7:0] A_r;
  logic [7:0] A_g;
  logic [7:0] A_b;
  logic       A_valid;
  logic       busy;

  modport master (
    output in_r, in_g, in_b, in_valid, in_sof, in_eof,
    input  A_r, A_g, A_b, A_valid, busy
  );

  modport slave (
    input  in_r, in_g, in_b, in_valid, in_sof, in_eof,
    output A_r, A_g, A_b, A_valid, busy
  );
endinterface

// File: rtl/atmo_light_est.sv
// Per-frame atmospheric-light estimator. Pixels whose dark channel reaches a
// threshold derived from the previous frame's brightest dark value are
// averaged (8-cycle restoring divide), clamped from below, IIR-smoothed and
// published once per frame on A_r/A_g/A_b with a one-cycle A_valid pulse.
module atmo_light_est #(
  parameter int CNT_W  = 22,
  parameter int MARGIN = 8,
  parameter int A_MIN  = 100
) (
  input logic             clk,
  input logic             rst_n,
  atmo_light_est_if.slave bus
);

  localparam int         SUM_W    = CNT_W + 8;
  localparam logic [7:0] LP_MARGIN = 8'(MARGIN);
  localparam logic [7:0] LP_A_MIN  = 8'(A_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DIV  = 2'd2,
    S_UPD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------
  function automatic logic [7:0] f_min3(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // Lower clamp keeps a dark frame from driving A towards zero.
  function automatic logic [7:0] f_clamp(input logic [7:0] a);
    return (a < LP_A_MIN) ? LP_A_MIN : a;
  endfunction

  // (3*old + new + 2) >> 2 ; worst case 3*255+255+2 = 1022 fits 10 bits.
  function automatic logic [7:0] f_smooth(input logic [7:0] a_old,
                                          input logic [7:0] a_new);
    logic [9:0] t;
    t = {2'b00, a_old} + {1'b0, a_old, 1'b0} + {2'b00, a_new} + 10'd2;
    return t[9:2];
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [SUM_W-1:0] r_sum_r, r_sum_g, r_sum_b;  // sums in ACC, remainders in DIV
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cur_max;
  logic [7:0]       r_prev_max;
  logic [7:0]       r_thr;
  logic             r_first_done;
  logic [SUM_W-1:0] r_den;                      // count shifted to current quotient bit
  logic [7:0]       r_q_r, r_q_g, r_q_b;
  logic [2:0]       r_step;
  logic [7:0]       r_A_r, r_A_g, r_A_b;
  logic             r_A_valid;
  logic             r_busy;

  // ---------------------------------------------------------------------
  // Pixel qualification and accumulate path
  // ---------------------------------------------------------------------
  logic [7:0]       w_dark;
  logic             w_restart;
  logic [7:0]       w_thr_new;
  logic [7:0]       w_thr_eff;
  logic [SUM_W-1:0] w_base_sum_r, w_base_sum_g, w_base_sum_b;
  logic [CNT_W-1:0] w_base_cnt;
  logic [7:0]       w_base_max;
  logic             w_qual;
  logic [SUM_W-1:0] w_acc_sum_r, w_acc_sum_g, w_acc_sum_b;
  logic [CNT_W-1:0] w_acc_cnt;
  logic [7:0]       w_acc_max;

  // A sof pixel is processed against freshly cleared accumulators and the
  // newly latched threshold, so the "base" values select between the two.
  always_comb begin
    w_dark       = f_min3(bus.in_r, bus.in_g, bus.in_b);
    w_restart    = bus.in_valid & bus.in_sof;
    w_thr_new    = (r_prev_max >= LP_MARGIN) ? (r_prev_max - LP_MARGIN) : 8'd0;
    w_thr_eff    = w_restart ? w_thr_new : r_thr;
    w_base_sum_r = w_restart ? '0 : r_sum_r;
    w_base_sum_g = w_restart ? '0 : r_sum_g;
    w_base_sum_b = w_restart ? '0 : r_sum_b;
    w_base_cnt   = w_restart ? '0 : r_cnt;
    w_base_max   = w_restart ? 8'd0 : r_cur_max;
    // Saturated count freezes both count and sums so the mean stays exact.
    w_qual       = (w_dark >= w_thr_eff) && (w_base_cnt != {CNT_W{1'b1}});
    w_acc_sum_r  = w_base_sum_r + (w_qual ? SUM_W'(bus.in_r) : '0);
    w_acc_sum_g  = w_base_sum_g + (w_qual ? SUM_W'(bus.in_g) : '0);
    w_acc_sum_b  = w_base_sum_b + (w_qual ? SUM_W'(bus.in_b) : '0);
    w_acc_cnt    = w_base_cnt + (w_qual ? CNT_W'(1) : '0);
    w_acc_max    = (w_dark > w_base_max) ? w_dark : w_base_max;
  end

  // ---------------------------------------------------------------------
  // Restoring divider step (three channels share the shifted divisor)
  // ---------------------------------------------------------------------
  logic             w_ge_r, w_ge_g, w_ge_b;
  logic [SUM_W-1:0] w_rem_r, w_rem_g, w_rem_b;

  // Sum <= 255*count, so starting the divisor at count<<7 yields an exact
  // 8-bit quotient after eight compare/subtract steps.
  always_comb begin
    w_ge_r  = (r_sum_r >= r_den);
    w_ge_g  = (r_sum_g >= r_den);
    w_ge_b  = (r_sum_b >= r_den);
    w_rem_r = w_ge_r ? (r_sum_r - r_den) : r_sum_r;
    w_rem_g = w_ge_g ? (r_sum_g - r_den) : r_sum_g;
    w_rem_b = w_ge_b ? (r_sum_b - r_den) : r_sum_b;
  end

  // ---------------------------------------------------------------------
  // Update path: fallback, clamp, smoothing
  // ---------------------------------------------------------------------
  logic       w_cnt_zero;
  logic [7:0] w_af_r, w_af_g, w_af_b;
  logic [7:0] w_new_r, w_new_g, w_new_b;

  // With no qualifying pixel the frame's brightest dark value stands in
  // for the mean; the first published A skips smoothing entirely.
  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_af_r     = w_cnt_zero ? r_cur_max : r_q_r;
    w_af_g     = w_cnt_zero ? r_cur_max : r_q_g;
    w_af_b     = w_cnt_zero ? r_cur_max : r_q_b;
    w_new_r    = r_first_done ? f_smooth(r_A_r, f_clamp(w_af_r)) : f_clamp(w_af_r);
    w_new_g    = r_first_done ? f_smooth(r_A_g, f_clamp(w_af_g)) : f_clamp(w_af_g);
    w_new_b    = r_first_done ? f_smooth(r_A_b, f_clamp(w_af_b)) : f_clamp(w_af_b);
  end

  // Frame FSM with accumulator, divider and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sum_r      <= '0;
      r_sum_g      <= '0;
      r_sum_b      <= '0;
      r_cnt        <= '0;
      r_cur_max    <= 8'd0;
      r_prev_max   <= 8'd255;
      r_thr        <= 8'd0;
      r_first_done <= 1'b0;
      r_den        <= '0;
      r_q_r        <= 8'd0;
      r_q_g        <= 8'd0;
      r_q_b        <= 8'd0;
      r_step       <= 3'd0;
      r_A_r        <= 8'd255;
      r_A_g        <= 8'd255;
      r_A_b        <= 8'd255;
      r_A_valid    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_A_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_ACC: begin
          // IDLE only wakes on sof; ACC takes every valid pixel.
          if (bus.in_valid && (w_restart || (r_state == S_ACC))) begin
            r_thr     <= w_thr_eff;
            r_sum_r   <= w_acc_sum_r;
            r_sum_g   <= w_acc_sum_g;
            r_sum_b   <= w_acc_sum_b;
            r_cnt     <= w_acc_cnt;
            r_cur_max <= w_acc_max;
            if (bus.in_eof) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_den   <= SUM_W'(w_acc_cnt) << 7;
              r_step  <= 3'd0;
              r_q_r   <= 8'd0;
              r_q_g   <= 8'd0;
              r_q_b   <= 8'd0;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_DIV: begin
          r_sum_r <= w_rem_r;
          r_sum_g <= w_rem_g;
          r_sum_b <= w_rem_b;
          r_q_r   <= {r_q_r[6:0], w_ge_r};
          r_q_g   <= {r_q_g[6:0], w_ge_g};
          r_q_b   <= {r_q_b[6:0], w_ge_b};
          r_den   <= r_den >> 1;
          r_step  <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          r_A_r        <= w_new_r;
          r_A_g        <= w_new_g;
          r_A_b        <= w_new_b;
          r_A_valid    <= 1'b1;
          r_first_done <= 1'b1;
          r_prev_max   <= r_cur_max;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.A_r     = r_A_r;
  assign bus.A_g     = r_A_g;
  assign bus.A_b     = r_A_b;
  assign bus.A_valid = r_A_valid;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_atmo_light_est.sv
// Directed bench for atmo_light_est: stimulus pushes expected A triples into
// a queue; an independent monitor pops one per A_valid pulse and compares.
module tb_atmo_light_est;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  atmo_light_est_if bus ();

  atmo_light_est #(
    .CNT_W (22),
    .MARGIN(8),
    .A_MIN (100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every A_valid pulse must match the oldest expected triple.
  always @(negedge clk) begin
    if (rst_n && bus.A_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_A_valid actual=%0d,%0d,%0d required=no_update",
                 bus.A_r, bus.A_g, bus.A_b);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("A_r", int'(bus.A_r), int'(mon_exp[23:16]));
        chk("A_g", int'(bus.A_g), int'(mon_exp[15:8]));
        chk("A_b", int'(bus.A_b), int'(mon_exp[7:0]));
        chk("busy_in_valid_cycle", int'(bus.busy), 0);
      end
    end
  end

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    bus.in_r     = 8'd0;
    bus.in_g     = 8'd0;
    bus.in_b     = 8'd0;
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic sof, input logic eof);
    @(negedge clk);
    bus.in_r     = r;
    bus.in_g     = g;
    bus.in_b     = b;
    bus.in_sof   = sof;
    bus.in_eof   = eof;
    bus.in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic expect_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_q.push_back({r, g, b});
  endtask

  // Bounded wait for all expected updates to drain and the block to go idle.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      drive_idle();
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout actual=pending%0d required=0", exp_q.size());
    end
    idle(2);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    if (check) begin
      chk("reset_A_r", int'(bus.A_r), 255);
      chk("reset_A_g", int'(bus.A_g), 255);
      chk("reset_A_b", int'(bus.A_b), 255);
      chk("reset_A_valid", int'(bus.A_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nb, nv;
    rst_n = 1'b1;
    drive_idle();
    do_reset(1'b1);

    // First frame: dark 160 < 247, no qualifiers -> fallback 160.
    expect_a(8'd160, 8'd160, 8'd160);
    px(8'd200, 8'd180, 8'd160, 1'b1, 1'b0);
    px(8'd200, 8'd180, 8'd160, 1'b0, 1'b0);
    px(8'd200, 8'd180, 8'd160, 1'b0, 1'b0);
    px(8'd200, 8'd180, 8'd160, 1'b0, 1'b1);
    @(posedge clk);  // E0
    lat = 0; nb = 0; nv = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive_idle();
      if (bus.busy) nb++;
      if (bus.A_valid) begin
        nv++;
        if (lat == 0) lat = k;
      end
    end
    chk("A_valid_cycle_after_eof", lat, 10);
    chk("busy_cycles", nb, 9);
    chk("A_valid_pulses", nv, 1);
    wait_done();

    // Second frame: thr 152, Af=(220,205,190), smoothed from 160.
    expect_a(8'd175, 8'd171, 8'd168);
    px(8'd200, 8'd180, 8'd160, 1'b1, 1'b0);
    px(8'd240, 8'd230, 8'd220, 1'b0, 1'b0);
    px(8'd10,  8'd10,  8'd10,  1'b0, 1'b1);
    wait_done();

    // Mid-ACC sof: only (230,225,215) and (226,221,213) count; thr 212.
    expect_a(8'd188, 8'd184, 8'd180);
    px(8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    px(8'd250, 8'd250, 8'd250, 1'b0, 1'b0);
    px(8'd230, 8'd225, 8'd215, 1'b1, 1'b0);
    px(8'd100, 8'd100, 8'd100, 1'b0, 1'b0);
    px(8'd226, 8'd221, 8'd213, 1'b0, 1'b1);
    wait_done();

    // Frame then a sof during DIV: that following frame must be ignored.
    expect_a(8'd195, 8'd192, 8'd189);
    px(8'd210, 8'd210, 8'd210, 1'b1, 1'b0);
    px(8'd220, 8'd220, 8'd220, 1'b0, 1'b1);
    idle(3);
    px(8'd250, 8'd250, 8'd250, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) px(8'd250, 8'd250, 8'd250, 1'b0, 1'b0);
    px(8'd250, 8'd250, 8'd250, 1'b0, 1'b1);
    wait_done();
    idle(20);
    chk("hold_A_r", int'(bus.A_r), 195);
    chk("hold_A_g", int'(bus.A_g), 192);
    chk("hold_A_b", int'(bus.A_b), 189);

    // Reset during DIV: no update for the interrupted frame.
    px(8'd240, 8'd240, 8'd240, 1'b1, 1'b0);
    px(8'd240, 8'd240, 8'd240, 1'b0, 1'b1);
    @(posedge clk);  // E0
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("middiv_A_r", int'(bus.A_r), 255);
    chk("middiv_A_g", int'(bus.A_g), 255);
    chk("middiv_A_b", int'(bus.A_b), 255);
    chk("middiv_busy", int'(bus.busy), 0);
    chk("middiv_A_valid", int'(bus.A_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    // First frame after reset, floor division: 752/3 = 250 (not 251), unsmoothed.
    expect_a(8'd250, 8'd250, 8'd250);
    px(8'd250, 8'd250, 8'd250, 1'b1, 1'b0);
    px(8'd251, 8'd251, 8'd251, 1'b0, 1'b0);
    px(8'd251, 8'd251, 8'd251, 1'b0, 1'b1);
    wait_done();

    // Clamp: single-pixel frames of (20,30,40).
    do_reset(1'b0);
    expect_a(8'd100, 8'd100, 8'd100);
    px(8'd20, 8'd30, 8'd40, 1'b1, 1'b1);
    wait_done();
    expect_a(8'd100, 8'd100, 8'd100);
    px(8'd20, 8'd30, 8'd40, 1'b1, 1'b1);
    wait_done();

    // Floor: 301/3 = 100, thr 12.
    expect_a(8'd100, 8'd100, 8'd100);
    px(8'd100, 8'd100, 8'd100, 1'b1, 1'b0);
    px(8'd100, 8'd100, 8'd100, 1'b0, 1'b0);
    px(8'd101, 8'd101, 8'd101, 1'b0, 1'b1);
    wait_done();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
